// File: rtl/apb_device_info_generic_if.sv
// ---------------------------------------------------------------------------
// apb_device_info_generic_if
// APB bus bundle for the device information block.
//   psel/penable/pwrite/paddr/pwdata : driven by the requester (master)
//   prdata/pready/pslverr            : driven by the completer (slave)
// No clock lives here: the block's pclk/preset_n stay plain module ports.
// ---------------------------------------------------------------------------
interface apb_device_info_generic_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_device_info_generic.sv
// ---------------------------------------------------------------------------
// apb_device_info_generic
// Device information block: after a boot delay it reads a serial-ID
// primitive (DNA style: load pulse, then one bit per shift), holds the
// result in an atomically updated serial register, offers software re-reads,
// a bank of scratch registers and a usercode pass-through.
//
// Ports
//   pclk, preset_n : single clock, asynchronous active-low reset
//   apb            : APB completer (psel/penable/pwrite/paddr/pwdata in,
//                    prdata/pready/pslverr out)
//   usercode       : static user word, returned combinationally
//   dna_read       : one-cycle load pulse to the ID primitive
//   dna_shift      : shift enable to the ID primitive
//   dna_dout       : serial data from the ID primitive (MSB first)
//   dbg_state      : current sequencer state (BOOT=0 LOAD=1 SHIFT=2 DONE=3)
//
// Handshake: zero wait states. A transfer completes in the cycle where
// psel & penable are both high (pready = psel & penable). prdata and pslverr
// are combinational and held at 0 whenever pready is low; writes take effect
// on the clock edge that ends the completing cycle.
// ---------------------------------------------------------------------------
module apb_device_info_generic #(
  parameter int          SERIAL_BITS  = 57,
  parameter int          BOOT_DELAY   = 16,
  parameter int          NUM_SCRATCH  = 2,
  parameter logic [31:0] SCRATCH_INIT = 32'h5555aaaa
) (
  input  logic                       pclk,
  input  logic                       preset_n,
  apb_device_info_generic_if.slave   apb,
  input  logic [31:0]                usercode,
  output logic                       dna_read,
  output logic                       dna_shift,
  input  logic                       dna_dout,
  output logic [1:0]                 dbg_state
);

  localparam int          SER_WORDS = (SERIAL_BITS + 31) / 32;
  localparam int          EXT_W     = 32 * SER_WORDS;
  localparam logic [7:0]  LAST_BIT  = 8'(SERIAL_BITS - 1);
  localparam logic [19:0] BOOT_END  = 20'(BOOT_DELAY);
  localparam logic [7:0]  PARAM_SB  = 8'(SERIAL_BITS);
  localparam logic [3:0]  PARAM_NS  = 4'(NUM_SCRATCH);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [19:0]            boot_cnt_q, boot_cnt_d;
  logic [7:0]             bit_cnt_q, bit_cnt_d;
  logic [SERIAL_BITS-1:0] shreg_q, shreg_d;
  logic [SERIAL_BITS-1:0] serial_q, serial_d;
  logic                   serial_valid_q, serial_valid_d;
  logic                   dna_read_q, dna_read_d;
  logic                   dna_shift_q, dna_shift_d;
  logic [31:0]            scratch_q [NUM_SCRATCH];
  logic [31:0]            scratch_d [NUM_SCRATCH];

  // Capture path: the shift register and the incoming bit side by side,
  // so the first bit received ends up as the MSB.
  logic [SERIAL_BITS:0]   cap;
  logic                   busy;
  logic                   pready;
  logic [5:0]             word;
  logic                   is_ser, is_scr;
  logic [1:0]             ser_k;
  logic [2:0]             scr_i;
  logic                   ser_ok, scr_ok;
  logic [31:0]            ser_word, scr_word;
  logic [EXT_W-1:0]       serial_ext;
  logic [31:0]            rdata;
  logic                   err;
  logic                   start_req;
  logic                   wr_scr;
  logic                   unused_addr_lsb;

  assign cap        = {shreg_q, dna_dout};
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign pready     = apb.psel & apb.penable;
  assign word       = apb.paddr[7:2];
  assign is_ser     = (word[5:2] == 4'b0001);
  assign ser_k      = word[1:0];
  assign is_scr     = (word[5:3] == 3'b010);
  assign scr_i      = word[2:0];
  assign serial_ext = EXT_W'(serial_q);
  assign unused_addr_lsb = ^apb.paddr[1:0];

  // Word 0 of the serial window is the most-significant 32 bits.
  always_comb begin
    ser_ok   = 1'b0;
    ser_word = '0;
    for (int k = 0; k < SER_WORDS; k++) begin
      if (ser_k == 2'(k)) begin
        ser_ok   = is_ser;
        ser_word = serial_ext[32*(SER_WORDS-1-k) +: 32];
      end
    end
  end

  always_comb begin
    scr_ok   = 1'b0;
    scr_word = '0;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (scr_i == 3'(i)) begin
        scr_ok   = is_scr;
        scr_word = scratch_q[i];
      end
    end
  end

  // APB decode: read mux, error flag and write strobes.
  always_comb begin
    rdata     = '0;
    err       = 1'b0;
    start_req = 1'b0;
    wr_scr    = 1'b0;
    if (pready) begin
      if (apb.pwrite) begin
        if (word == 6'd1) begin
          // bit0=0 is accepted silently; a start while busy is refused
          if (apb.pwdata[0]) begin
            if (busy) err = 1'b1;
            else      start_req = 1'b1;
          end
        end else if (scr_ok) begin
          wr_scr = 1'b1;
        end else begin
          err = 1'b1;
        end
      end else begin
        case (word)
          6'd0:    rdata = {30'h0, busy, serial_valid_q};
          6'd2:    rdata = {20'h0, PARAM_NS, PARAM_SB};
          6'd3:    rdata = usercode;
          default: begin
            if (ser_ok)      rdata = ser_word;
            else if (scr_ok) rdata = scr_word;
            else             err   = 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      scratch_d[i] = (wr_scr && (scr_i == 3'(i))) ? apb.pwdata : scratch_q[i];
    end
  end

  // Sequencer. dna_read/dna_shift are registered alongside the state so
  // they line up with the state they belong to.
  always_comb begin
    state_d        = state_q;
    boot_cnt_d     = boot_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    shreg_d        = shreg_q;
    serial_d       = serial_q;
    serial_valid_d = serial_valid_q;
    dna_read_d     = 1'b0;
    dna_shift_d    = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_END) begin
          state_d    = ST_LOAD;
          dna_read_d = 1'b1;
        end else begin
          boot_cnt_d = boot_cnt_q + 20'd1;
        end
      end
      ST_LOAD: begin
        state_d     = ST_SHIFT;
        bit_cnt_d   = '0;
        // a 1-bit ID needs no shift at all: its only SHIFT cycle is the last
        dna_shift_d = (SERIAL_BITS != 1);
      end
      ST_SHIFT: begin
        shreg_d   = cap[SERIAL_BITS-1:0];
        bit_cnt_d = bit_cnt_q + 8'd1;
        if (bit_cnt_q == LAST_BIT) begin
          // whole value published in one edge: readers never see a mix
          serial_d       = cap[SERIAL_BITS-1:0];
          serial_valid_d = 1'b1;
          state_d        = ST_DONE;
        end else begin
          dna_shift_d = ((bit_cnt_q + 8'd1) != LAST_BIT);
        end
      end
      ST_DONE: begin
        if (start_req) begin
          state_d    = ST_LOAD;
          dna_read_d = 1'b1;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q        <= ST_BOOT;
      boot_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      shreg_q        <= '0;
      serial_q       <= '0;
      serial_valid_q <= 1'b0;
      dna_read_q     <= 1'b0;
      dna_shift_q    <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= SCRATCH_INIT;
    end else begin
      state_q        <= state_d;
      boot_cnt_q     <= boot_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      serial_q       <= serial_d;
      serial_valid_q <= serial_valid_d;
      dna_read_q     <= dna_read_d;
      dna_shift_q    <= dna_shift_d;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= scratch_d[i];
    end
  end

  assign apb.prdata  = rdata;
  assign apb.pslverr = err;
  assign apb.pready  = pready;
  assign dna_read    = dna_read_q;
  assign dna_shift   = dna_shift_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_device_info_generic.sv
// ---------------------------------------------------------------------------
// tb_apb_device_info_generic
// Two instances: dut_a with default parameters, dut_b with SERIAL_BITS=96,
// BOOT_DELAY=0, NUM_SCRATCH=8. Each has a behavioural ID primitive model:
// dna_read loads the value, dna_shift moves it left, dout is the MSB.
// ---------------------------------------------------------------------------
module tb_apb_device_info_generic;

  logic        pclk;
  logic        rst_a_n, rst_b_n;
  logic [31:0] usercode_a, usercode_b;
  logic        dna_read_a, dna_shift_a, dna_dout_a;
  logic        dna_read_b, dna_shift_b, dna_dout_b;
  logic [1:0]  dbg_state_a, dbg_state_b;

  logic [56:0] model_a_val, sh_a;
  logic [95:0] model_b_val, sh_b;

  int          edge_cnt = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q [$];

  apb_device_info_generic_if bus_a ();
  apb_device_info_generic_if bus_b ();

  apb_device_info_generic dut_a (
    .pclk      (pclk),
    .preset_n  (rst_a_n),
    .apb       (bus_a),
    .usercode  (usercode_a),
    .dna_read  (dna_read_a),
    .dna_shift (dna_shift_a),
    .dna_dout  (dna_dout_a),
    .dbg_state (dbg_state_a)
  );

  apb_device_info_generic #(
    .SERIAL_BITS (96),
    .BOOT_DELAY  (0),
    .NUM_SCRATCH (8)
  ) dut_b (
    .pclk      (pclk),
    .preset_n  (rst_b_n),
    .apb       (bus_b),
    .usercode  (usercode_b),
    .dna_read  (dna_read_b),
    .dna_shift (dna_shift_b),
    .dna_dout  (dna_dout_b),
    .dbg_state (dbg_state_b)
  );

  // ---------------- clock / edge counter ----------------
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) edge_cnt <= edge_cnt + 1;

  // ---------------- ID primitive models ----------------
  always @(posedge pclk) begin
    if (dna_read_a)       sh_a <= model_a_val;
    else if (dna_shift_a) sh_a <= sh_a << 1;
  end
  assign dna_dout_a = sh_a[56];

  always @(posedge pclk) begin
    if (dna_read_b)       sh_b <= model_b_val;
    else if (dna_shift_b) sh_b <= sh_b << 1;
  end
  assign dna_dout_b = sh_b[95];

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit sel_b, input logic ps, input logic pe, input logic wr,
                       input logic [7:0] addr, input logic [31:0] wdata);
    if (sel_b) begin
      bus_b.psel = ps; bus_b.penable = pe; bus_b.pwrite = wr;
      bus_b.paddr = addr; bus_b.pwdata = wdata;
    end else begin
      bus_a.psel = ps; bus_a.penable = pe; bus_a.pwrite = wr;
      bus_a.paddr = addr; bus_a.pwdata = wdata;
    end
  endtask

  // Setup on one negedge, access on the next; sampled 1 ns into the access
  // phase; the write commits on the posedge that follows.
  task automatic xfer(input bit sel_b, input logic wr, input logic [7:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    @(negedge pclk);
    drive(sel_b, 1'b1, 1'b0, wr, addr, wdata);
    @(negedge pclk);
    drive(sel_b, 1'b1, 1'b1, wr, addr, wdata);
    #1;
    if (sel_b) begin rdata = bus_b.prdata; err = bus_b.pslverr; end
    else       begin rdata = bus_a.prdata; err = bus_a.pslverr; end
    @(negedge pclk);
    drive(sel_b, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic rd(input bit sel_b, input logic [7:0] addr, input logic [31:0] exp_data,
                    input logic exp_err, input string tag);
    logic [31:0] d;
    logic        e;
    exp_q.push_back({exp_err, exp_data});
    xfer(sel_b, 1'b0, addr, 32'h0, d, e);
    chk(tag, {31'h0, e, d}, {31'h0, exp_q.pop_front()});
  endtask

  task automatic wr(input bit sel_b, input logic [7:0] addr, input logic [31:0] data,
                    input logic exp_err, input string tag);
    logic [31:0] d;
    logic        e;
    exp_q.push_back({exp_err, 32'h0});
    xfer(sel_b, 1'b1, addr, data, d, e);
    chk(tag, {31'h0, e, 32'h0}, {31'h0, exp_q.pop_front()});
  endtask

  // Return 1 ns after the posedge that makes edge_cnt reach x.
  task automatic wait_edge(input int x);
    int guard = 0;
    while (edge_cnt < x && guard < 2000) begin
      @(posedge pclk); #1; guard++;
    end
  endtask

  // Edge index at which dna_read is first seen high, or -1 on timeout.
  task automatic wait_dna_read(input bit sel_b, output int e);
    int n = 0;
    e = -1;
    while (n < 200) begin
      @(posedge pclk); #1; n++;
      if (sel_b ? dna_read_b : dna_read_a) begin
        e = edge_cnt;
        break;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int r0, e, c;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    rst_a_n     = 1'b0;
    rst_b_n     = 1'b0;
    usercode_a  = 32'hcafe0001;
    usercode_b  = 32'h0bad0b0b;
    model_a_val = 57'h0adbeef_c0def00d;
    model_b_val = {$urandom, $urandom, $urandom};
    repeat (3) @(negedge pclk);

    // reset state
    chk("rst_dna_read", {63'h0, dna_read_a}, 64'h0);
    chk("rst_dna_shift", {63'h0, dna_shift_a}, 64'h0);
    rd(1'b0, 8'h00, 32'h0, 1'b0, "rst_status");
    rd(1'b0, 8'h40, 32'h5555aaaa, 1'b0, "rst_scratch0");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h0c, 32'h0);
    #1;
    chk("setup_no_ready", {31'h0, bus_a.pready, bus_a.prdata}, 64'h0);
    @(negedge pclk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);

    // first read after boot delay
    rst_a_n = 1'b1;
    r0 = edge_cnt;
    wait_dna_read(1'b0, e);
    chk("boot_latency", 64'(e - r0), 64'd17);
    @(posedge pclk); #1;
    chk("dna_read_width", {63'h0, dna_read_a}, 64'h0);
    wait_edge(e + 1);
    rd(1'b0, 8'h00, 32'h2, 1'b0, "status_shifting");
    wait_edge(e + 56);
    rd(1'b0, 8'h00, 32'h2, 1'b0, "status_before_done");
    rd(1'b0, 8'h00, 32'h1, 1'b0, "status_done");
    rd(1'b0, 8'h10, 32'h00adbeef, 1'b0, "serial0");
    rd(1'b0, 8'h14, 32'hc0def00d, 1'b0, "serial1");
    rd(1'b0, 8'h08, 32'h239, 1'b0, "params_a");

    // scratch
    wr(1'b0, 8'h44, 32'h12345678, 1'b0, "scratch1_wr");
    rd(1'b0, 8'h44, 32'h12345678, 1'b0, "scratch1_rd");
    rd(1'b0, 8'h40, 32'h5555aaaa, 1'b0, "scratch0_keep");

    // access errors
    rd(1'b0, 8'h04, 32'h0, 1'b1, "ctrl_read_err");
    rd(1'b0, 8'h48, 32'h0, 1'b1, "scratch2_unmapped");
    rd(1'b0, 8'h18, 32'h0, 1'b1, "serial2_unmapped");
    wr(1'b0, 8'h10, 32'hffffffff, 1'b1, "serial_write_err");
    rd(1'b0, 8'h10, 32'h00adbeef, 1'b0, "serial0_unchanged");
    rd(1'b0, 8'h0c, 32'hcafe0001, 1'b0, "usercode");
    wr(1'b0, 8'h04, 32'h0, 1'b0, "ctrl_zero_ok");
    rd(1'b0, 8'h00, 32'h1, 1'b0, "status_no_start");

    // software re-read
    model_a_val = 57'h1;
    wr(1'b0, 8'h04, 32'h1, 1'b0, "ctrl_start");
    c = edge_cnt;
    rd(1'b0, 8'h00, 32'h3, 1'b0, "status_reread");
    rd(1'b0, 8'h14, 32'hc0def00d, 1'b0, "serial1_atomic");
    wr(1'b0, 8'h04, 32'h1, 1'b1, "ctrl_start_busy");
    wait_edge(c + 60);
    rd(1'b0, 8'h00, 32'h1, 1'b0, "status_reread_done");
    rd(1'b0, 8'h10, 32'h0, 1'b0, "serial0_reread");
    rd(1'b0, 8'h14, 32'h1, 1'b0, "serial1_reread");

    // reset in the middle of a shift (bit 30)
    model_a_val = 57'h0adbeef_c0def00d;
    wr(1'b0, 8'h04, 32'h1, 1'b0, "ctrl_start2");
    c = edge_cnt;
    wait_edge(c + 31);
    chk("mid_shift_active", {63'h0, dna_shift_a}, 64'h1);
    rst_a_n = 1'b0;
    #1;
    chk("abort_dna_shift", {63'h0, dna_shift_a}, 64'h0);
    rd(1'b0, 8'h00, 32'h0, 1'b0, "abort_status");
    rd(1'b0, 8'h14, 32'h0, 1'b0, "abort_serial_clr");
    rst_a_n = 1'b1;
    r0 = edge_cnt;
    wait_dna_read(1'b0, e);
    chk("reboot_latency", 64'(e - r0), 64'd17);
    wait_edge(e + 57);
    rd(1'b0, 8'h00, 32'h1, 1'b0, "status_latency_58");
    rd(1'b0, 8'h10, 32'h00adbeef, 1'b0, "reboot_serial0");
    rd(1'b0, 8'h14, 32'hc0def00d, 1'b0, "reboot_serial1");

    // 96-bit instance, zero boot delay
    @(negedge pclk);
    rst_b_n = 1'b1;
    r0 = edge_cnt;
    wait_dna_read(1'b1, e);
    chk("b_boot_latency", 64'(e - r0), 64'd1);
    wait_edge(e + 99);
    rd(1'b1, 8'h00, 32'h1, 1'b0, "b_status");
    rd(1'b1, 8'h10, model_b_val[95:64], 1'b0, "b_serial0");
    rd(1'b1, 8'h14, model_b_val[63:32], 1'b0, "b_serial1");
    rd(1'b1, 8'h18, model_b_val[31:0], 1'b0, "b_serial2");
    rd(1'b1, 8'h1c, 32'h0, 1'b1, "b_serial3_unmapped");
    rd(1'b1, 8'h08, 32'h860, 1'b0, "b_params");
    wr(1'b1, 8'h5c, 32'ha5a50f0f, 1'b0, "b_scratch7_wr");
    rd(1'b1, 8'h5c, 32'ha5a50f0f, 1'b0, "b_scratch7_rd");
    rd(1'b1, 8'h40, 32'h5555aaaa, 1'b0, "b_scratch0_keep");
    rd(1'b1, 8'h0c, 32'h0bad0b0b, 1'b0, "b_usercode");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_device_info_generic.md
Name: apb_device_info_generic

Overview:
Parametrised, single-clock-domain device information block for the APB register space. It sequences a DNA-style serial-ID primitive of configurable bit length after a configurable boot delay, and holds the result in atomically updated registers. It also supports software-triggered re-reads, a configurable bank of scratch registers, and passes through a usercode word. It sits on a peripheral APB segment and replaces per-family hard-coded info blocks wherever the ID primitive can be clocked from pclk.

Parameters:
SERIAL_BITS, 57, serial ID length in bits, legal range 1..128.
BOOT_DELAY, 16, pclk cycles to wait after reset release before the first read, legal range 0..2^20-1.
NUM_SCRATCH, 2, number of 32-bit scratch registers, legal range 1..8.
SCRATCH_INIT, 32'h5555aaaa, reset value of every scratch register.

Ports:
pclk  input  1  APB clock; the only clock in the block.
preset_n  input  1  asynchronous active-low reset.
psel  input  1  APB select.
penable  input  1  APB enable.
pwrite  input  1  APB write (1) / read (0).
paddr  input  8  byte address; bits [1:0] are ignored.
pwdata  input  32  write data.
prdata  output  32  read data.
pready  output  1  transfer complete.
pslverr  output  1  transfer error.
usercode  input  32  static user ID word, read combinationally.
dna_read  output  1  load pulse to the ID primitive.
dna_shift  output  1  shift enable to the ID primitive.
dna_dout  input  1  serial data from the ID primitive.

Behaviour:
- Reset, asynchronous: state=BOOT, boot counter=0, bit counter=0, serial register=0, serial_valid=0, scratch[i]=SCRATCH_INIT, dna_read=0, dna_shift=0.
- APB handshake:
  - Zero wait states: pready = psel & penable.
  - prdata and pslverr are combinational and are 0 unless pready=1.
- Register map (word addresses):
  - 0x00 STATUS (RO): [0]=serial_valid, [1]=busy, where busy = state is LOAD or SHIFT. Other bits 0.
  - 0x04 CONTROL (WO): writing bit0=1 starts a re-read. Reads of 0x04 raise pslverr.
  - 0x08 PARAMS (RO): [7:0]=SERIAL_BITS, [11:8]=NUM_SCRATCH.
  - 0x0C USERCODE (RO): returns usercode.
  - 0x10+4k SERIAL_k (RO), k < W where W = ceil(SERIAL_BITS/32). The serial value is zero-extended to 32*W bits; k=0 returns the most-significant word. Example for 57 bits: SERIAL_0 = {7'h0, serial[56:32]}, SERIAL_1 = serial[31:0].
  - 0x40+4i SCRATCH_i (RW), i < NUM_SCRATCH.
- Access errors:
  - Any read of an unmapped address, or any write to an address other than CONTROL or SCRATCH: pslverr=1, prdata=0, no side effects.
  - A CONTROL write with bit0=1 while busy: pslverr=1, ignored.
  - A CONTROL write with bit0=0: accepted, no effect.
- State machine:
  - BOOT: the counter increments each cycle. When counter==BOOT_DELAY, go to LOAD. With BOOT_DELAY=0, LOAD is entered on the first edge after reset release.
  - LOAD: dna_read=1 for exactly one cycle; bit counter=0; go to SHIFT.
  - SHIFT, each cycle:
    - Capture shreg <= {shreg, dna_dout}, so the first bit received becomes the MSB.
    - dna_shift=1 on every SHIFT cycle except the last.
    - Bit counter increments.
    - On the capture of bit SERIAL_BITS-1: the serial register is loaded with the full value in the same edge, serial_valid is set to 1, and the state goes to DONE.
  - DONE: idle. An accepted CONTROL start moves to LOAD.
- Atomicity: SERIAL_k registers never show partial data. During a re-read they keep the previous value and serial_valid stays 1.
- Latency: from the dna_read cycle to serial_valid/serial register update is SERIAL_BITS+1 cycles.
- Scratch writes take effect on the edge where pready & pwrite & address match.
- Asserting preset_n low mid-SHIFT immediately aborts the read, clears serial_valid and the serial register, and restarts BOOT.

Test Plan:
- Defaults; bench ID model holds 57'h0adbeef_c0def00d; release reset. Required response:
  - dna_read pulses once, 17 edges after reset release.
  - STATUS reads 0x2 while shifting.
  - STATUS reads 0x1 after 58 more cycles.
  - SERIAL_0 = 0x00adbeef, SERIAL_1 = 0xc0def00d.
- Read SCRATCH_0 after reset -> 0x5555aaaa. Write 0x12345678 to 0x44, then read 0x44 -> 0x12345678, and 0x40 still reads 0x5555aaaa.
- Bench changes the model value to 57'h1, then writes CONTROL=1. Required response:
  - During the re-read, STATUS=0x3 and SERIAL_1 still reads 0xc0def00d.
  - Afterwards, SERIAL_0=0 and SERIAL_1=1.
  - A second CONTROL=1 write issued while busy returns pslverr=1.
- Access errors:
  - Read 0x04 -> pslverr=1, prdata=0.
  - Read 0x48 (NUM_SCRATCH=2) -> pslverr=1.
  - Write 0x10 -> pslverr=1, serial unchanged.
  - Read 0x0C with usercode=0xcafe0001 -> 0xcafe0001.
- SERIAL_BITS=96, BOOT_DELAY=0, NUM_SCRATCH=8, random 96-bit model value. Required response:
  - dna_read is asserted on the first edge after reset.
  - SERIAL_0..2 match the model value MSW first.
  - PARAMS=0x860.
  - 0x5C is writable.
- Assert preset_n low at shift bit 30. Required response:
  - dna_shift drops asynchronously, STATUS=0.
  - After release, a full sequence repeats and yields the correct serial.
